// File: rtl/fifo_sinc_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output; otherwise data_out is a registered read.
module fifo_sinc_param #(
    parameter int unsigned WIDTH            = 8,
    parameter int unsigned DEPTH            = 16,
    parameter int unsigned CASI_LLENO_NIVEL = DEPTH - 2,
    parameter int unsigned CASI_VACIO_NIVEL = 2,
    localparam int unsigned CW              = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             lleno,
    output logic             vacio,
    output logic             casi_lleno,
    output logic             casi_vacio,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_lleno;
    logic             w_vacio;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;

    // Flags decode straight from the registered count, so they cannot glitch against it.
    assign w_lleno    = (r_count == CW'(DEPTH));
    assign w_vacio    = (r_count == '0);
    assign lleno      = w_lleno;
    assign vacio      = w_vacio;
    assign casi_lleno = (r_count >= CW'(CASI_LLENO_NIVEL));
    assign casi_vacio = (r_count <= CW'(CASI_VACIO_NIVEL));
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign w_rd_ok = rd_en & ~w_vacio;
    assign w_wr_ok = wr_en & (~w_lleno | w_rd_ok);

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_wr_ok && !w_rd_ok) begin
            r_count <= r_count + CW'(1);
        end else if (w_rd_ok && !w_wr_ok) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Error pulses last exactly one cycle after the rejected request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= wr_en & ~w_wr_ok;
            r_underflow <= rd_en & ~w_rd_ok;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented combinationally; rd_en only pops it.
    assign data_out = w_vacio ? '0 : r_mem[r_rd_ptr];
`else
    logic [WIDTH-1:0] r_data_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (w_rd_ok) begin
            r_data_out <= r_mem[r_rd_ptr];
        end
    end

    assign data_out = r_data_out;
`endif

endmodule

// File: tb/tb_fifo_sinc_param.sv
// Self-checking bench for fifo_sinc_param: directed table, corner sequences and a queue-model random run.
module tb_fifo_sinc_param;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       lleno;
    logic       vacio;
    logic       casi_lleno;
    logic       casi_vacio;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_checks = 0;
    int n_errors = 0;

    fifo_sinc_param dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .data_in   (data_in),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .lleno     (lleno),
        .vacio     (vacio),
        .casi_lleno(casi_lleno),
        .casi_vacio(casi_vacio),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: a plain queue of stored words.
    logic [7:0] q[$];
    logic [7:0] m_dout;
    bit         m_ovf;
    bit         m_unf;

    typedef struct {
        bit         wr;
        logic [7:0] din;
        bit         rd;
        int         cnt;
        bit         ovf;
        bit         unf;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_dout();
`ifdef FIFO_FWFT_EN
        return (q.size() == 0) ? 8'h00 : q[0];
`else
        return m_dout;
`endif
    endfunction

    task automatic model_step(input bit wr, input logic [7:0] din, input bit rd);
        bit full, empty, rd_ok, wr_ok;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        rd_ok = rd && !empty;
        wr_ok = wr && (!full || rd_ok);
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(din);
        m_ovf = wr && !wr_ok;
        m_unf = rd && !rd_ok;
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_all();
        chk("count",      32'(count),      32'(q.size()));
        chk("lleno",      32'(lleno),      32'(q.size() == DEPTH));
        chk("vacio",      32'(vacio),      32'(q.size() == 0));
        chk("casi_lleno", 32'(casi_lleno), 32'(q.size() >= 14));
        chk("casi_vacio", 32'(casi_vacio), 32'(q.size() <= 2));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        chk("underflow",  32'(underflow),  32'(m_unf));
        chk("data_out",   32'(data_out),   32'(exp_dout()));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"},      32'(count),      32'd0);
        chk({tag, "_vacio"},      32'(vacio),      32'd1);
        chk({tag, "_casi_vacio"}, 32'(casi_vacio), 32'd1);
        chk({tag, "_lleno"},      32'(lleno),      32'd0);
        chk({tag, "_casi_lleno"}, 32'(casi_lleno), 32'd0);
        chk({tag, "_data_out"},   32'(data_out),   32'h00);
        chk({tag, "_overflow"},   32'(overflow),   32'd0);
        chk({tag, "_underflow"},  32'(underflow),  32'd0);
    endtask

    task automatic step(input bit wr, input logic [7:0] din, input bit rd);
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        @(posedge clk);
        #1;
        model_step(wr, din, rd);
        check_all();
    endtask

    initial begin
        logic [7:0] prev;
        int         nxt;
        int         pw;
        vec_t       v;

        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        model_reset();

        // Fill, overflow, drain and underflow as a fixed vector table.
        for (int i = 0; i < 16; i++) tbl.push_back('{1'b1, 8'(i), 1'b0, i + 1, 1'b0, 1'b0, 8'h00});
        tbl.push_back('{1'b1, 8'hAA, 1'b0, 16, 1'b1, 1'b0, 8'h00});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 16, 1'b0, 1'b0, 8'h00});
        for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
            tbl.push_back('{1'b0, 8'h00, 1'b1, 15 - i, 1'b0, 1'b0, (i == 15) ? 8'h00 : 8'(i + 1)});
`else
            tbl.push_back('{1'b0, 8'h00, 1'b1, 15 - i, 1'b0, 1'b0, 8'(i)});
`endif
        end
`ifdef FIFO_FWFT_EN
        tbl.push_back('{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h00});
`else
        tbl.push_back('{1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b1, 8'h0F});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 8'h0F});
`endif

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v       = tbl[i];
            wr_en   = v.wr;
            data_in = v.din;
            rd_en   = v.rd;
            @(posedge clk);
            #1;
            model_step(v.wr, v.din, v.rd);
            chk($sformatf("tbl%0d_count", i),      32'(count),      32'(v.cnt));
            chk($sformatf("tbl%0d_lleno", i),      32'(lleno),      32'(v.cnt == 16));
            chk($sformatf("tbl%0d_vacio", i),      32'(vacio),      32'(v.cnt == 0));
            chk($sformatf("tbl%0d_casi_lleno", i), 32'(casi_lleno), 32'(v.cnt >= 14));
            chk($sformatf("tbl%0d_casi_vacio", i), 32'(casi_vacio), 32'(v.cnt <= 2));
            chk($sformatf("tbl%0d_overflow", i),   32'(overflow),   32'(v.ovf));
            chk($sformatf("tbl%0d_underflow", i),  32'(underflow),  32'(v.unf));
            chk($sformatf("tbl%0d_data_out", i),   32'(data_out),   32'(v.dout));
        end

        // Streaming through the pointer wrap: ordered words 0x10..0x23.
        nxt = 'h10;
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 12; i++) begin
`ifdef FIFO_FWFT_EN
            chk("wrap_order", 32'(data_out), 32'(nxt));
            step(1'b1, 8'(8'h18 + i), 1'b1);
`else
            step(1'b1, 8'(8'h18 + i), 1'b1);
            chk("wrap_order", 32'(data_out), 32'(nxt));
`endif
            nxt++;
        end
        for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
            chk("wrap_order", 32'(data_out), 32'(nxt));
            step(1'b0, 8'h00, 1'b1);
`else
            step(1'b0, 8'h00, 1'b1);
            chk("wrap_order", 32'(data_out), 32'(nxt));
`endif
            nxt++;
        end
        prev = data_out;
        step(1'b0, 8'h00, 1'b1);
        chk("wrap_underflow", 32'(underflow), 32'd1);
`ifndef FIFO_FWFT_EN
        chk("wrap_dout_held", 32'(data_out), 32'(prev));
`endif
        step(1'b0, 8'h00, 1'b0);
        chk("wrap_underflow_off", 32'(underflow), 32'd0);

        // Simultaneous read and write while full.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        chk("full_rw_count", 32'(count), 32'd16);
        chk("full_rw_lleno", 32'(lleno), 32'd1);
        chk("full_rw_ovf",   32'(overflow), 32'd0);
`ifdef FIFO_FWFT_EN
        chk("full_rw_head", 32'(data_out), 32'h31);
`else
        chk("full_rw_oldest", 32'(data_out), 32'h30);
`endif
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
        chk("full_rw_last", 32'(data_out), 32'hEE);
`endif

        // Simultaneous read and write while empty.
        step(1'b1, 8'h77, 1'b1);
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_unf",   32'(underflow), 32'd1);
        step(1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
        chk("empty_rw_data", 32'(data_out), 32'h77);
`endif

        // Asynchronous reset between edges with 9 words stored.
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0);
        chk("mid_count9", 32'(count), 32'd9);
        #3;
        rst = 1'b0;
        #1;
        check_reset_vals("midrst");
        model_reset();
        #2;
        rst = 1'b1;
        step(1'b1, 8'h5A, 1'b0);
`ifdef FIFO_FWFT_EN
        chk("midrst_5a", 32'(data_out), 32'h5A);
`endif
        step(1'b0, 8'h00, 1'b1);
`ifndef FIFO_FWFT_EN
        chk("midrst_5a", 32'(data_out), 32'h5A);
`endif

        // Random traffic with alternating bias to reach both full and empty.
        for (int i = 0; i < 800; i++) begin
            pw = ((i / 100) % 2 == 0) ? 80 : 25;
            step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < (100 - pw));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
